// File: rtl/logic_result_wb_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : logic_result_wb_buffer_if
// Description : Producer-side and register-file-side handshake bundle for the
//               logic-result writeback buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface logic_result_wb_buffer_if #(
  parameter int WL = 32,
  parameter int SL = 5,
  parameter int RL = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [WL-1:0] in_result;
  logic [SL-1:0] in_select;
  logic [RL-1:0] in_rd;
  logic          out_valid;
  logic          out_ready;
  logic [WL-1:0] out_result;
  logic [RL-1:0] out_rd;
  logic          out_zero;
  logic          out_neg;

  modport master (
    output in_valid, in_result, in_select, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_zero, out_neg
  );

  modport slave (
    input  in_valid, in_result, in_select, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_zero, out_neg
  );
endinterface
`default_nettype wire

// File: rtl/logic_result_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : logic_result_wb_buffer
// Description : Show-ahead FIFO between the logic unit and the register-file
//               write port; stores result, destination and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_result_wb_buffer #(
  parameter int WL    = 32,
  parameter int SL    = 5,
  parameter int RL    = 5,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  logic_result_wb_buffer_if.slave        bus,
  output logic [CW-1:0]                  count,
  output logic                           full,
  output logic                           empty
);

  localparam int              PW         = $clog2(DEPTH);
  localparam logic [SL-2:0]   C_SEL_SLT  = (SL-1)'(12);

  logic [WL-1:0]    r_mem_result [DEPTH];
  logic [RL-1:0]    r_mem_rd     [DEPTH];
  logic [DEPTH-1:0] r_mem_zero;
  logic [DEPTH-1:0] r_mem_neg;

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_in_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_zero;
  logic             w_neg;

  assign full       = (r_count == CW'(DEPTH));
  assign empty      = (r_count == '0);
  assign count      = r_count;

  assign w_in_ready = !full && !flush;
  // A handshake to r0 completes but is never stored.
  assign w_push     = bus.in_valid && w_in_ready && (bus.in_rd != '0);
  assign w_pop      = !empty && bus.out_ready && !flush;

  // slt produces a boolean, so its MSB is never a sign.
  assign w_zero     = (bus.in_result == '0);
  assign w_neg      = bus.in_result[WL-1] && (bus.in_select[SL-2:0] != C_SEL_SLT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_result[r_wr_ptr] <= bus.in_result;
      r_mem_rd[r_wr_ptr]     <= bus.in_rd;
      r_mem_zero[r_wr_ptr]   <= w_zero;
      r_mem_neg[r_wr_ptr]    <= w_neg;
    end
  end

  // Head outputs are masked to zero whenever nothing is buffered.
  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = !empty;
  assign bus.out_result = empty ? '0   : r_mem_result[r_rd_ptr];
  assign bus.out_rd     = empty ? '0   : r_mem_rd[r_rd_ptr];
  assign bus.out_zero   = empty ? 1'b0 : r_mem_zero[r_rd_ptr];
  assign bus.out_neg    = empty ? 1'b0 : r_mem_neg[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_logic_result_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_result_wb_buffer
// Description : Directed and randomized checks of the writeback buffer
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_result_wb_buffer;
  localparam int WL = 32, SL = 5, RL = 5, DEPTH = 4, CW = 3;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          flush = 1'b0;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  logic_result_wb_buffer_if #(.WL(WL), .SL(SL), .RL(RL)) bus ();

  logic_result_wb_buffer #(.WL(WL), .SL(SL), .RL(RL), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WL-1:0] result;
    logic [RL-1:0] rd;
    logic          zero;
    logic          neg;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   m_push, m_pop;
  logic [WL-1:0] exp_r [4];

  task automatic chk(input string nm, input logic [WL-1:0] act, input logic [WL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ent_t make_ent(input logic [WL-1:0] r, input logic [SL-1:0] s,
                                    input logic [RL-1:0] d);
    ent_t e;
    e.result = r;
    e.rd     = d;
    e.zero   = (r == 0);
    e.neg    = r[WL-1] && (s[3:0] != 4'hC);
    return e;
  endfunction

  // Reference model: a plain queue updated from the inputs seen at each edge.
  always @(posedge clk) begin
    if (rst || flush) begin
      q.delete();
    end else begin
      m_push = bus.in_valid && (q.size() < DEPTH);
      m_pop  = (q.size() > 0) && bus.out_ready;
      if (m_pop) void'(q.pop_front());
      if (m_push && bus.in_rd != 0) q.push_back(make_ent(bus.in_result, bus.in_select, bus.in_rd));
    end
  end

  always @(negedge clk) begin
    ent_t h;
    bit   v;
    v = (q.size() > 0);
    h = v ? q[0] : '0;
    chk("out_valid",  {31'b0, bus.out_valid}, {31'b0, v});
    chk("out_result", bus.out_result, h.result);
    chk("out_rd",     {27'b0, bus.out_rd}, {27'b0, h.rd});
    chk("out_zero",   {31'b0, bus.out_zero}, {31'b0, h.zero});
    chk("out_neg",    {31'b0, bus.out_neg}, {31'b0, h.neg});
    chk("count",      {29'b0, count}, q.size());
    chk("full",       {31'b0, full}, {31'b0, q.size() == DEPTH});
    chk("empty",      {31'b0, empty}, {31'b0, q.size() == 0});
    chk("in_ready",   {31'b0, bus.in_ready}, {31'b0, (q.size() < DEPTH) && !flush});
  end

  task automatic drive(input logic v, input logic [WL-1:0] r, input logic [SL-1:0] s,
                       input logic [RL-1:0] d, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_result = r;
    bus.in_select = s;
    bus.in_rd     = d;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, '0, '0, '0, ordy, 1'b0);
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [WL-1:0] rr;
    bus.in_valid = 0; bus.in_result = 0; bus.in_select = 0; bus.in_rd = 0; bus.out_ready = 0;
    exp_r[0] = 32'h8000_0001; exp_r[1] = 32'h1; exp_r[2] = 32'h2; exp_r[3] = 32'h3;

    mid();
    chk("rst_count", {29'b0, count}, 0);
    chk("rst_empty", {31'b0, empty}, 1);
    chk("rst_full", {31'b0, full}, 0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
    @(posedge clk); #1; rst = 0;

    // Single push of a zero result, then pop
    drive(1, 32'h0, 5'h02, 3, 0, 0);
    idle(0); mid();
    chk("t1_valid", {31'b0, bus.out_valid}, 1);
    chk("t1_result", bus.out_result, 0);
    chk("t1_rd", {27'b0, bus.out_rd}, 3);
    chk("t1_zero", {31'b0, bus.out_zero}, 1);
    chk("t1_neg", {31'b0, bus.out_neg}, 0);
    chk("t1_count", {29'b0, count}, 1);
    idle(1);
    idle(0); mid();
    chk("t1_empty", {31'b0, empty}, 1);
    chk("t1_rd_after", {27'b0, bus.out_rd}, 0);
    chk("t1_zero_after", {31'b0, bus.out_zero}, 0);

    // Fill to full, hold a fifth push, drain in order
    drive(1, 32'h8000_0001, 5'h00, 1, 0, 0);
    drive(1, 32'h1, 5'h02, 2, 0, 0);
    drive(1, 32'h2, 5'h02, 3, 0, 0);
    drive(1, 32'h3, 5'h02, 4, 0, 0);
    drive(1, 32'h4, 5'h02, 5, 0, 0); mid();
    chk("t2_full", {31'b0, full}, 1);
    chk("t2_in_ready", {31'b0, bus.in_ready}, 0);
    chk("t2_count", {29'b0, count}, 4);
    for (int i = 0; i < 4; i++) begin
      idle(1); mid();
      chk("t2_drain_result", bus.out_result, exp_r[i]);
      chk("t2_drain_rd", {27'b0, bus.out_rd}, i + 1);
      if (i == 0) chk("t2_neg", {31'b0, bus.out_neg}, 1);
    end
    idle(0);

    // slt suppresses neg; neighbouring opcode does not
    drive(1, 32'hFFFF_FFFF, 5'h0C, 7, 0, 0);
    idle(0); mid();
    chk("t3_slt_neg", {31'b0, bus.out_neg}, 0);
    chk("t3_slt_zero", {31'b0, bus.out_zero}, 0);
    drive(1, 32'hFFFF_FFFF, 5'h0B, 7, 1, 0);
    idle(0); mid();
    chk("t3_0b_neg", {31'b0, bus.out_neg}, 1);
    chk("t3_0b_count", {29'b0, count}, 1);
    idle(1);
    idle(0);

    // Steady push+pop at count 2 across pointer wrap
    drive(1, 32'h100, 5'h02, 1, 0, 0);
    drive(1, 32'h101, 5'h02, 2, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h200 + i, 5'h02, RL'((i % 7) + 3), 1, 0); mid();
      chk("t4_count", {29'b0, count}, 2);
    end
    idle(1); idle(1);
    idle(0); mid();
    chk("t4_empty", {31'b0, empty}, 1);

    // rd=0 push is accepted but discarded
    drive(1, 32'hA, 5'h02, 5, 0, 0);
    drive(1, 32'h55, 5'h02, 0, 0, 0);
    drive(1, 32'hB, 5'h02, 6, 0, 0);
    idle(0); mid();
    chk("t5_count", {29'b0, count}, 2);
    chk("t5_head_rd", {27'b0, bus.out_rd}, 5);
    idle(1); mid();
    chk("t5_first_rd", {27'b0, bus.out_rd}, 5);
    idle(1); mid();
    chk("t5_second_rd", {27'b0, bus.out_rd}, 6);
    chk("t5_second_result", bus.out_result, 32'hB);
    idle(0);

    // Asynchronous reset mid-cycle
    drive(1, 32'h31, 5'h02, 1, 0, 0);
    drive(1, 32'h32, 5'h02, 2, 0, 0);
    drive(1, 32'h33, 5'h02, 3, 0, 0);
    idle(0); mid();
    chk("t6_count3", {29'b0, count}, 3);
    @(posedge clk); #3;
    rst = 1; #1;
    q.delete();
    chk("t6_async_valid", {31'b0, bus.out_valid}, 0);
    chk("t6_async_empty", {31'b0, empty}, 1);
    chk("t6_async_count", {29'b0, count}, 0);
    chk("t6_async_result", bus.out_result, 0);
    @(posedge clk); #1; rst = 0;

    // Flush overrides a simultaneous push and pop
    drive(1, 32'h11, 5'h02, 1, 0, 0);
    drive(1, 32'h22, 5'h02, 2, 0, 0);
    drive(1, 32'h33, 5'h02, 3, 1, 1); mid();
    chk("t7_flush_in_ready", {31'b0, bus.in_ready}, 0);
    chk("t7_flush_count_before", {29'b0, count}, 2);
    idle(0); mid();
    chk("t7_flush_count_after", {29'b0, count}, 0);
    chk("t7_flush_valid", {31'b0, bus.out_valid}, 0);

    // Randomized traffic
    repeat (500) begin
      case ($urandom % 4)
        0:       rr = 32'h0;
        1:       rr = 32'hFFFF_FFFF;
        default: rr = $urandom;
      endcase
      drive(($urandom % 4) != 0, rr, SL'($urandom), RL'($urandom_range(0, 7)),
            ($urandom % 2) == 0, ($urandom % 30) == 0);
    end
    idle(1);
    repeat (6) @(posedge clk);
    @(negedge clk); #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
